// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue queue.
// Holds the ALU opcode encodings, the tag width, the "no tag" value,
// the queue entry record and the CDB wake-up helper used by the queue.
package alu_pkg;

  // Tag width; tag value 0 means "no producer / value ready / no result".
  localparam int TAG_W = 3;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t NO_TAG = '0;

  // ALU opcode encodings
  localparam logic [4:0] ADD   = 5'b00000;
  localparam logic [4:0] SUB   = 5'b00001;
  localparam logic [4:0] SLL   = 5'b00010;
  localparam logic [4:0] SLT   = 5'b00011;
  localparam logic [4:0] SLTU  = 5'b00100;
  localparam logic [4:0] XOR   = 5'b00101;
  localparam logic [4:0] SRL   = 5'b00110;
  localparam logic [4:0] SRA   = 5'b00111;
  localparam logic [4:0] OR    = 5'b01000;
  localparam logic [4:0] AND   = 5'b01001;
  localparam logic [4:0] LUI   = 5'b01010;
  localparam logic [4:0] AUIPC = 5'b01011;
  localparam logic [4:0] BEQ   = 5'b01100;
  localparam logic [4:0] BNE   = 5'b01101;
  localparam logic [4:0] BLT   = 5'b01110;
  localparam logic [4:0] BGE   = 5'b01111;
  localparam logic [4:0] JAL   = 5'b10000;
  localparam logic [4:0] JALR  = 5'b10001;

  // One reservation entry: operand value plus the tag still awaited for it.
  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [31:0] v1;
    tag_t        q1;
    logic [31:0] v2;
    tag_t        q2;
    tag_t        des;
  } entry_t;

  // Capture a CDB broadcast into a valid entry waiting on that tag.
  // A broadcast on NO_TAG carries no result and is ignored.
  function automatic entry_t wake(input entry_t      e,
                                  input logic        cdb_valid,
                                  input tag_t        cdb_tag,
                                  input logic [31:0] cdb_value);
    entry_t r;
    r = e;
    if (e.valid && cdb_valid && (cdb_tag != NO_TAG)) begin
      if (e.q1 == cdb_tag) begin
        r.v1 = cdb_value;
        r.q1 = NO_TAG;
      end
      if (e.q2 == cdb_tag) begin
        r.v2 = cdb_value;
        r.q2 = NO_TAG;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Bus interface of the ALU issue queue: allocation port, CDB snoop port,
// flush, registered ALU drive and occupancy.
//
// Handshake: an instruction is accepted at a posedge exactly when in_valid
// and in_ready are both 1 at that edge (and flush is 0). in_ready depends
// only on the registered occupancy, never on in_valid; the sender may hold
// or change in_valid freely and must keep the in_* payload stable while
// in_valid is 1 and in_ready is 0 if it wants that instruction accepted.
interface alu_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = alu_pkg::TAG_W
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [TAG_W-1:0] in_des;
  logic [31:0]      in_v1;
  logic [31:0]      in_v2;
  logic [TAG_W-1:0] in_q1;
  logic [TAG_W-1:0] in_q2;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             flush;

  logic [4:0]       alu_op;
  logic [31:0]      alu_value_1;
  logic [31:0]      alu_value_2;
  logic [TAG_W-1:0] alu_des;

  logic [CW-1:0]    count;

  // Producer side (dispatch / testbench)
  modport master (
    output in_valid, in_op, in_des, in_v1, in_v2, in_q1, in_q2,
    output cdb_valid, cdb_tag, cdb_value, flush,
    input  in_ready, alu_op, alu_value_1, alu_value_2, alu_des, count
  );

  // Queue side
  modport slave (
    input  in_valid, in_op, in_des, in_v1, in_v2, in_q1, in_q2,
    input  cdb_valid, cdb_tag, cdb_value, flush,
    output in_ready, alu_op, alu_value_1, alu_value_2, alu_des, count
  );

endinterface

// File: rtl/alu_issue_pick.sv
// Oldest-ready selector: grants the lowest-index set bit of the ready
// vector. Index 0 is the oldest entry, so this is an age-ordered pick.
module alu_issue_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  // Scan from the oldest entry and grant the first ready one.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        gnt[i] = 1'b1;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order-allocated, oldest-ready-first ALU issue queue.
// Entries sit in allocation order (index 0 oldest) and are compacted when
// one issues. Waiting operands capture results from the CDB; an entry with
// both operands present in registered state issues to the registered ALU
// drive. Flush and reset empty the queue and idle the ALU drive.
//
// Optional build: define ALU_ISSUE_QUEUE_BYPASS_EN to send an already-ready
// incoming instruction straight to the ALU drive (no allocation) whenever the
// queue holds no ready entry.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = alu_pkg::TAG_W
) (
  input logic           clk,
  input logic           rst,
  alu_issue_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  entry_t         ent_q [DEPTH];
  logic [CW-1:0]  count_q;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] gnt;
  logic             any_rdy;

  logic           hs;
  logic           issue;
  logic           bypass;
  logic           alloc;
  logic [CW-1:0]  alloc_idx;
  logic [CW-1:0]  count_nxt;
  logic           removed;

  entry_t         new_ent;
  entry_t         woke [DEPTH+1];
  entry_t         nxt  [DEPTH];

  logic [4:0]     pick_op;
  logic [31:0]    pick_v1;
  logic [31:0]    pick_v2;
  tag_t           pick_des;

  logic [4:0]     out_op;
  logic [31:0]    out_v1;
  logic [31:0]    out_v2;
  tag_t           out_des;

  assign bus.in_ready = (count_q < CW'(DEPTH));
  assign bus.count    = count_q;

  // Ready means both operands present in the registered entry; a CDB
  // capture this cycle only becomes issuable on the next one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = ent_q[i].valid && (ent_q[i].q1 == NO_TAG) && (ent_q[i].q2 == NO_TAG);
    end
  end

  alu_issue_pick #(.N(DEPTH)) u_pick (
    .req (rdy),
    .gnt (gnt),
    .any (any_rdy)
  );

  // Incoming instruction, with the CDB snooped so a result broadcast in the
  // allocation cycle is not missed.
  always_comb begin
    new_ent.valid = 1'b1;
    new_ent.op    = bus.in_op;
    new_ent.v1    = bus.in_v1;
    new_ent.q1    = bus.in_q1;
    new_ent.v2    = bus.in_v2;
    new_ent.q2    = bus.in_q2;
    new_ent.des   = bus.in_des;
    new_ent       = wake(new_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
  end

  // Per-cycle control: accept, issue, optional bypass; flush overrides all.
  always_comb begin
    hs    = bus.in_valid && bus.in_ready && !bus.flush;
    issue = any_rdy && !bus.flush;
`ifdef ALU_ISSUE_QUEUE_BYPASS_EN
    bypass = hs && !any_rdy && (new_ent.q1 == NO_TAG) && (new_ent.q2 == NO_TAG);
`else
    bypass = 1'b0;
`endif
    alloc     = hs && !bypass;
    alloc_idx = count_q - CW'(issue);
    count_nxt = count_q + CW'(alloc) - CW'(issue);
  end

  // CDB wake-up of every queued entry; the extra slot is an empty filler
  // shifted into the top position during compaction.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end
    woke[DEPTH] = '0;
  end

  // Compact past the issued entry, then append the new one at the tail.
  always_comb begin
    removed = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      removed = removed | (issue & gnt[i]);
      nxt[i]  = removed ? woke[i+1] : woke[i];
      if (alloc && (alloc_idx == CW'(i))) begin
        nxt[i] = new_ent;
      end
    end
  end

  // Fields of the granted entry (grant is one-hot or zero).
  always_comb begin
    pick_op  = '0;
    pick_v1  = '0;
    pick_v2  = '0;
    pick_des = NO_TAG;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) begin
        pick_op  = ent_q[i].op;
        pick_v1  = ent_q[i].v1;
        pick_v2  = ent_q[i].v2;
        pick_des = ent_q[i].des;
      end
    end
  end

  // Next ALU drive: issued entry, bypassed instruction, or idle zeros.
  always_comb begin
    out_op  = '0;
    out_v1  = '0;
    out_v2  = '0;
    out_des = NO_TAG;
    if (bus.flush) begin
      out_op  = '0;
    end else if (issue) begin
      out_op  = pick_op;
      out_v1  = pick_v1;
      out_v2  = pick_v2;
      out_des = pick_des;
    end else if (bypass) begin
      out_op  = new_ent.op;
      out_v1  = new_ent.v1;
      out_v2  = new_ent.v2;
      out_des = new_ent.des;
    end
  end

  // Queue storage and occupancy; flush empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= nxt[i];
      end
      count_q <= count_nxt;
    end
  end

  // Registered ALU drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alu_op      <= '0;
      bus.alu_value_1 <= '0;
      bus.alu_value_2 <= '0;
      bus.alu_des     <= '0;
    end else begin
      bus.alu_op      <= out_op;
      bus.alu_value_1 <= out_v1;
      bus.alu_value_2 <= out_v2;
      bus.alu_des     <= out_des;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed testbench for alu_issue_queue (default build, DEPTH=4, TAG_W=3).
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int W = 72;  // {op, v1, v2, des}

  logic clk;
  logic rst;

  alu_issue_queue_if #(.DEPTH(4), .TAG_W(3)) bus ();

  alu_issue_queue #(.DEPTH(4), .TAG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [4:0] op, input logic [31:0] v1,
                                        input logic [31:0] v2, input logic [2:0] des);
    return {op, v1, v2, des};
  endfunction

  task automatic push(input logic [4:0] op, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [2:0] des);
    exp_q.push_back(pack(op, v1, v2, des));
  endtask

  task automatic check_out();
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {bus.alu_op, bus.alu_value_1, bus.alu_value_2, bus.alu_des};
    if (bus.alu_des != 3'd0) begin
      check("issue_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("issue_data", obs, exp);
      end
    end else begin
      check("idle_zero", obs, '0);
    end
  endtask

  task automatic check_cnt(input string tag, input int exp);
    check(tag, W'(bus.count), W'(exp));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [4:0] op, input logic [31:0] v1, input logic [2:0] q1,
                       input logic [31:0] v2, input logic [2:0] q2, input logic [2:0] des);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_v1    = v1;
    bus.in_q1    = q1;
    bus.in_v2    = v2;
    bus.in_q2    = q2;
    bus.in_des   = des;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [31:0] val);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_value = val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v2s [4];
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.flush = 1'b0;
    idle_in();
    bus.in_op = '0; bus.in_v1 = '0; bus.in_q1 = '0;
    bus.in_v2 = '0; bus.in_q2 = '0; bus.in_des = '0;
    cdb(1'b0, 3'd0, 32'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_cnt("rst_count", 0);
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_alu", {bus.alu_op, bus.alu_value_1, bus.alu_value_2, bus.alu_des}, '0);
    #2 rst = 1'b1;

    // Single ready ADD: one cycle in the queue, then issues
    drive(ADD, 32'd5, 3'd0, 32'd7, 3'd0, 3'd3);
    push(ADD, 32'd5, 32'd7, 3'd3);
    tick();
    check_cnt("add_count_alloc", 1);
    idle_in();
    tick();
    check("add_issue_des", W'(bus.alu_des), W'(3));
    check_cnt("add_count_drain", 0);

    // Younger ready entry overtakes older waiting one
    drive(SUB, 32'd0, 3'd2, 32'd11, 3'd0, 3'd1);
    tick();
    drive(XOR, 32'd3, 3'd0, 32'd4, 3'd0, 3'd2);
    push(XOR, 32'd3, 32'd4, 3'd2);
    tick();
    check_cnt("ooo_count", 2);
    idle_in();
    cdb(1'b1, 3'd2, 32'd9);
    push(SUB, 32'd9, 32'd11, 3'd1);
    tick();
    check("ooo_first_des", W'(bus.alu_des), W'(2));
    cdb(1'b0, 3'd0, 32'd0);
    tick();
    check("ooo_second_des", W'(bus.alu_des), W'(1));
    check_cnt("ooo_count_drain", 0);

    // Fill to DEPTH with waiting entries, wake all, full+issue drops input
    for (int k = 0; k < 4; k++) begin
      v2s[k] = $urandom_range(1, 32'hFFFF);
      drive(5'(k), 32'd0, 3'd5, v2s[k], 3'd0, 3'(k + 1));
      tick();
    end
    check_cnt("full_count", 4);
    check("full_in_ready", W'(bus.in_ready), W'(0));
    idle_in();
    cdb(1'b1, 3'd5, 32'h1234);
    for (int k = 0; k < 4; k++) push(5'(k), 32'h1234, v2s[k], 3'(k + 1));
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    drive(OR, 32'd1, 3'd0, 32'd2, 3'd0, 3'd7);
    tick();
    idle_in();
    check_cnt("full_issue_no_alloc", 3);
    repeat (3) tick();
    check_cnt("full_drain", 0);
    check("drain_in_ready", W'(bus.in_ready), W'(1));

    // CDB tag 0 carries no result and must not touch ready operands
    drive(LUI, 32'h55, 3'd0, 32'h66, 3'd0, 3'd5);
    cdb(1'b1, 3'd0, 32'hFFFF_FFFF);
    push(LUI, 32'h55, 32'h66, 3'd5);
    tick();
    idle_in();
    cdb(1'b0, 3'd0, 32'd0);
    tick();

    // Allocation snoops the CDB in the same cycle
    drive(AND, 32'd20, 3'd0, 32'd0, 3'd4, 3'd6);
    cdb(1'b1, 3'd4, 32'hDEADBEEF);
    push(AND, 32'd20, 32'hDEADBEEF, 3'd6);
    tick();
    idle_in();
    cdb(1'b0, 3'd0, 32'd0);
    tick();
    check("snoop_v2", W'(bus.alu_value_2), W'(32'hDEADBEEF));

    // Allocate, issue and wake-up together
    drive(SRL, 32'd0, 3'd3, 32'd8, 3'd0, 3'd1);
    tick();
    drive(SRA, 32'd1, 3'd0, 32'd2, 3'd0, 3'd2);
    push(SRA, 32'd1, 32'd2, 3'd2);
    tick();
    drive(BEQ, 32'd40, 3'd0, 32'd0, 3'd3, 3'd3);
    cdb(1'b1, 3'd3, 32'h77);
    push(SRL, 32'h77, 32'd8, 3'd1);
    push(BEQ, 32'd40, 32'h77, 3'd3);
    tick();
    check_cnt("simul_count", 2);
    idle_in();
    cdb(1'b0, 3'd0, 32'd0);
    repeat (2) tick();
    check_cnt("simul_drain", 0);

    // Flush with 3 waiting entries, simultaneous allocation and wake-up
    for (int k = 0; k < 3; k++) begin
      drive(BNE, 32'(k), 3'd7, 32'd1, 3'd0, 3'(k + 1));
      tick();
    end
    check_cnt("pre_flush_count", 3);
    drive(BLT, 32'd2, 3'd0, 32'd3, 3'd0, 3'd4);
    cdb(1'b1, 3'd7, 32'hAA);
    bus.flush = 1'b1;
    tick();
    check_cnt("flush_count", 0);
    check("flush_des", W'(bus.alu_des), W'(0));
    bus.flush = 1'b0;
    idle_in();
    cdb(1'b1, 3'd7, 32'hBB);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    repeat (2) tick();
    check_cnt("post_flush_count", 0);

    // Asynchronous reset mid-operation with two waiting entries
    drive(JAL, 32'd1, 3'd6, 32'd2, 3'd0, 3'd1);
    tick();
    drive(JALR, 32'd3, 3'd6, 32'd4, 3'd0, 3'd2);
    tick();
    drive(AUIPC, 32'h100, 3'd0, 32'h200, 3'd0, 3'd5);
    push(AUIPC, 32'h100, 32'h200, 3'd5);
    tick();
    idle_in();
    tick();
    check_cnt("pre_rst_count", 2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_alu", {bus.alu_op, bus.alu_value_1, bus.alu_value_2, bus.alu_des}, '0);
    check_cnt("async_rst_count", 0);
    check("async_rst_ready", W'(bus.in_ready), W'(1));
    #2 rst = 1'b1;
    cdb(1'b1, 3'd6, 32'h99);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    repeat (2) tick();
    check_cnt("post_rst_count", 0);

    check("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
